// File: rtl/cpu_defs.sv
// Definitions shared by the fetch/PC stage and the multicycle control FSM:
// opcode and funct encodings, plus the fetch state encoding.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH_REQ = 2'd1,
        ST_HOLD      = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JR, J/JAL, conditional branch, or pc+4.
// Also flags the illegal beq+bne combination.
module next_pc_calc
    import cpu_defs::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        illegal_br
);

    logic signed [31:0] br_off;
    logic               br_taken;
    logic        [31:0] jr_tgt;

    always_comb begin
        br_off     = $signed({{14{instr[15]}}, instr[15:0], 2'b00});
        br_taken   = (beq & zero) | (bne & ~zero);
        illegal_br = beq & bne;
        // JR targets are forced to word alignment rather than trapping
        jr_tgt     = rs_val & 32'hFFFF_FFFC;
        next_pc    = pc_plus4;
        if (jump && (instr[31:26] == OP_RTYPE)) begin
            next_pc = jr_tgt;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (br_taken) begin
            next_pc = pc_plus4 + $unsigned(br_off);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / PC stage: fetches over a req/ack handshake, holds the
// instruction register for the control FSM, and advances the PC on pc_update.
module fetch_pc_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_update,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [31:0] rs_val,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam logic [15:0] TO_LIM = 16'(ACK_TIMEOUT);

    fetch_state_e state, state_nx;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic [15:0]  to_cnt;
    logic         illegal_br;
    logic         retire;
    logic         bad_update;
    logic         timeout_hit;
    logic         err_set;

    next_pc_calc u_next_pc (
        .pc_plus4   (pc_plus4),
        .instr      (instr),
        .rs_val     (rs_val),
        .jump       (jump),
        .beq        (beq),
        .bne        (bne),
        .zero       (zero),
        .next_pc    (next_pc),
        .illegal_br (illegal_br)
    );

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        retire      = 1'b0;
        bad_update  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx   = ST_FETCH_REQ;
                bad_update = pc_update;
            end
            ST_FETCH_REQ: begin
                imem_req   = 1'b1;
                bad_update = pc_update;
                if (imem_ack) begin
                    state_nx = ST_HOLD;
                end else if ((TO_LIM != 16'd0) && (to_cnt + 16'd1 == TO_LIM)) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (pc_update) begin
                    retire   = 1'b1;
                    state_nx = ST_FETCH_REQ;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        err_set = bad_update | timeout_hit | (retire & illegal_br);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            instr     <= '0;
            to_cnt    <= '0;
            fetch_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (err_set) begin
                fetch_err <= 1'b1;
            end
            if ((state == ST_FETCH_REQ) && imem_ack) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc <= next_pc;
            end
            // Counter saturates at the limit so a stuck request cannot wrap it
            if ((state == ST_FETCH_REQ) && !imem_ack) begin
                if ((TO_LIM != 16'd0) && (to_cnt != TO_LIM)) begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign imm16     = instr[15:0];

endmodule
